weight_code_gen: RTL and testbench
==================================

WEIGHT_CODE_GEN -- requirements
Module: weight_code_gen

Interface
REQ-001 SHALL have parameter none; all widths fixed (code 4 bits, count 4 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a generation run; sampled only in IDLE.
REQ-005 clear  input  1  synchronous abort; return to IDLE next edge.
REQ-006 wsel  input  2  weight select: 00 = weight 2 or 3, 01 = weight 2 only, 10 = weight 3 only, 11 = treated as 00.
REQ-007 ready  input  1  consumer accepts code when ready && valid.
REQ-008 code  output  4  current candidate word; meaningful while valid.
REQ-009 valid  output  1  code holds a word of the selected weight.
REQ-010 busy  output  1  high in SEARCH, EMIT, DONE.
REQ-011 done  output  1  one-cycle pulse in DONE state.
REQ-012 count  output  4  number of words accepted in the current run.

Function
REQ-013 States SHALL be IDLE, SEARCH, EMIT, DONE; encoding free.
REQ-014 IDLE: start=1 SHALL latch wsel (11 mapped to 00), set candidate=0, count=0, go SEARCH.
REQ-015 SEARCH: candidate popcount in latched weight set SHALL go EMIT with candidate unchanged; else candidate 15 SHALL go DONE; else candidate+1, stay.
REQ-016 EMIT: valid=1, code=candidate; code SHALL stay stable until handshake.
REQ-017 EMIT handshake (ready=1): count+1, candidate+1, go SEARCH; valid low for at least one cycle between words.
REQ-018 Candidate 15 (weight 4) SHALL never be emitted; candidates 0..2 never emitted.
REQ-019 Emission order SHALL be ascending: wsel=00 -> 3,5,6,7,9,10,11,12,13,14; 01 -> 3,5,6,9,10,12; 10 -> 7,11,13,14.
REQ-020 Latency: valid SHALL rise on the 4th edge after the edge sampling start for wsel=00/01, the 8th for wsel=10.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE (see REQ-029); count holds final value (10, 6 or 4) until next start.
REQ-022 start while busy SHALL be ignored; wsel changes mid-run SHALL have no effect.
REQ-023 clear SHALL override all other transitions incl. a same-cycle handshake; count retains value; valid and done low next cycle.
REQ-024 ready while valid=0 SHALL have no effect.
REQ-025 Outputs SHALL be registered.

Reset
REQ-026 nrst=0 SHALL immediately force IDLE, code=0, valid=0, busy=0, done=0, count=0, candidate=0, latched wsel=00.
REQ-027 Reset mid-run SHALL discard the run; no done pulse.
REQ-028 After nrst release the first start SHALL be honoured on the first edge.

Configuration
REQ-029 Macro WCG_REPEAT_EN: defined -> DONE returns to SEARCH with candidate=0, count=0, looping until clear or reset, done pulsing once per pass; undefined -> DONE returns to IDLE.

Verification
REQ-030 nrst low, then release, start=1 wsel=00, ready=1 -> codes 3,5,6,7,9,10,11,12,13,14, done pulse once, count=10.
REQ-031 wsel=10, ready held 0 for 5 cycles at first valid -> code=7 held stable, accepted on ready, then 11,13,14, count=4.
REQ-032 wsel=01 run, clear asserted in same cycle as handshake of code 6 -> IDLE, no done, count=2.
REQ-033 start pulsed again during run, wsel changed to 10 mid-run -> sequence unchanged.
REQ-034 nrst pulsed low during EMIT of code 9 -> valid=0 at once, count=0, no done.
REQ-035 With WCG_REPEAT_EN, wsel=10 ready=1 -> 7,11,13,14 repeated, done every pass, stops after clear.

Source files
------------

// File: rtl/weight_code_gen_if.sv
// Handshake/status bundle for weight_code_gen: run control, weight select,
// and the emitted code word with its valid/ready handshake.
interface weight_code_gen_if;
  logic       start;
  logic       clear;
  logic [1:0] wsel;
  logic       ready;
  logic [3:0] code;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] count;

  modport master (
    output start, clear, wsel, ready,
    input  code, valid, busy, done, count
  );

  modport slave (
    input  start, clear, wsel, ready,
    output code, valid, busy, done, count
  );
endinterface

// File: rtl/weight_code_gen.sv
// Emits, in ascending order, every 4-bit word whose popcount is in the selected
// weight set (2, 3 or both). Optional macro WCG_REPEAT_EN loops runs until clear.
module weight_code_gen (
  input  logic            clk,
  input  logic            nrst,
  weight_code_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    EMIT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [1:0] wsel_q, wsel_d;
  logic [3:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // wsel 11 never reaches here: it is folded to 00 when latched
  function automatic logic weight_ok(input logic [3:0] c, input logic [1:0] ws);
    logic [2:0] pop;
    pop = 3'(c[0]) + 3'(c[1]) + 3'(c[2]) + 3'(c[3]);
    case (ws)
      2'b01:   weight_ok = (pop == 3'd2);
      2'b10:   weight_ok = (pop == 3'd3);
      default: weight_ok = (pop == 3'd2) || (pop == 3'd3);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    wsel_d  = wsel_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          wsel_d  = (bus.wsel == 2'b11) ? 2'b00 : bus.wsel;
          cand_d  = '0;
          count_d = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (weight_ok(cand_q, wsel_q)) begin
          state_d = EMIT;
        end else if (cand_q == 4'hF) begin
          state_d = DONE;
        end else begin
          cand_d = cand_q + 4'd1;
        end
      end
      EMIT: begin
        if (bus.ready) begin
          count_d = count_q + 4'd1;
          cand_d  = cand_q + 4'd1;
          state_d = SEARCH;
        end
      end
      DONE: begin
`ifdef WCG_REPEAT_EN
        cand_d  = '0;
        count_d = '0;
        state_d = SEARCH;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a same-cycle handshake; count is kept
    if (bus.clear) begin
      state_d = IDLE;
      cand_d  = cand_q;
      count_d = count_q;
    end

    // Status outputs are decoded from the next state so they leave a flop
    valid_d = (state_d == EMIT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      wsel_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      wsel_q  <= wsel_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.code  = cand_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_weight_code_gen.sv
// Scoreboard bench for weight_code_gen: runs push the expected word list from a
// popcount model; a negedge monitor checks every presented word, count and done.
module tb_weight_code_gen;

  logic clk;
  logic nrst;

  weight_code_gen_if bus();

  weight_code_gen dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int expq[$];
  int exp_count = 0;
  int done_cnt = 0;
  bit prev_hs = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Reference: every word 0..15 whose popcount is in the selected weight set
  task automatic build_expected(input logic [1:0] ws);
    expq.delete();
    for (int v = 0; v < 16; v++) begin
      int w;
      bit take;
      w = $countones(4'(v));
      if (ws == 2'b01)      take = (w == 2);
      else if (ws == 2'b10) take = (w == 3);
      else                  take = (w == 2) || (w == 3);
      if (take) expq.push_back(v);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_hs = 1'b0;
      end else begin
        chk("count", bus.count, exp_count);
        if (prev_hs) chk("valid_gap", bus.valid, 0);
        prev_hs = 1'b0;
        if (bus.valid) begin
          if (expq.size() == 0) begin
            chk("unexpected_word", bus.code, 99);
          end else begin
            chk("code", bus.code, expq[0]);
            if (bus.ready && !bus.clear) begin
              void'(expq.pop_front());
              exp_count++;
              prev_hs = 1'b1;
            end
          end
        end
        if (bus.done) begin
          done_cnt++;
          chk("done_queue_empty", expq.size(), 0);
        end
      end
    end
  end

  task automatic do_reset();
    nrst      = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.ready = 1'b0;
    bus.wsel  = 2'b00;
    exp_count = 0;
    expq.delete();
    #1;
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy",  bus.busy,  0);
    chk("rst_done",  bus.done,  0);
    chk("rst_count", bus.count, 0);
    chk("rst_code",  bus.code,  0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic run(input logic [1:0] ws, input int rdy_pct, input bit perturb,
                     input int lat, input int clr_at, input int rst_code);
    int exp_len;
    bit fin;
    bit abort;
    @(posedge clk); #1;
    build_expected(ws);
    exp_len   = expq.size();
    bus.start = 1'b1;
    bus.wsel  = ws;
    bus.ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    exp_count = 0;
    done_cnt  = 0;
    fin       = 1'b0;
    abort     = 1'b0;
    for (int cyc = 1; cyc <= 600 && !fin && !abort; cyc++) begin
      @(posedge clk); #1;
      if (lat > 1 && cyc == lat - 1) chk("latency_pre", bus.valid, 0);
      if (lat > 0 && cyc == lat)     chk("latency_valid", bus.valid, 1);
      if (bus.done) begin
        fin = 1'b1;
      end else if (clr_at >= 0 && bus.valid && exp_count == clr_at) begin
        bus.clear = 1'b1;
        bus.ready = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        bus.ready = 1'b0;
        chk("clear_valid", bus.valid, 0);
        chk("clear_done",  bus.done,  0);
        chk("clear_busy",  bus.busy,  0);
        chk("clear_count", bus.count, clr_at);
        expq.delete();
        abort = 1'b1;
      end else if (rst_code >= 0 && bus.valid && int'(bus.code) == rst_code) begin
        nrst      = 1'b0;
        bus.ready = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_count", bus.count, 0);
        chk("midrst_busy",  bus.busy,  0);
        chk("midrst_done",  bus.done,  0);
        chk("midrst_code",  bus.code,  0);
        exp_count = 0;
        expq.delete();
        @(posedge clk); #1;
        nrst  = 1'b1;
        abort = 1'b1;
      end else begin
        bus.ready = ($urandom_range(1, 100) <= rdy_pct);
        if (perturb) begin
          bus.start = ($urandom_range(0, 3) == 0);
          bus.wsel  = 2'($urandom_range(0, 3));
        end
      end
    end
    bus.start = 1'b0;
    bus.ready = 1'b0;
    if (!abort) begin
      chk("run_finished", fin, 1);
      @(posedge clk); #1;
      chk("end_busy",        bus.busy,    0);
      chk("end_done",        bus.done,    0);
      chk("done_pulses",     done_cnt,    1);
      chk("final_count",     bus.count,   exp_len);
      chk("queue_drained",   expq.size(), 0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      chk("abort_busy",    bus.busy, 0);
    end
  endtask

  initial begin
    do_reset();
    run(2'b00, 100, 1'b0, 4, -1, -1);
    run(2'b10, 25,  1'b0, 8, -1, -1);
    run(2'b01, 100, 1'b0, 4,  2, -1);
    run(2'b00, 60,  1'b1, 0, -1, -1);
    run(2'b00, 100, 1'b0, 0, -1,  9);
    run(2'b11, 70,  1'b0, 4, -1, -1);
    run(2'b01, 50,  1'b1, 4, -1, -1);
    for (int r = 0; r < 6; r++) begin
      run(2'($urandom_range(0, 3)), $urandom_range(20, 100),
          1'($urandom_range(0, 1)), 0, -1, -1);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
